// File: rtl/mfm_sector_reader_pkg.sv
// Shared types and constants for the MFM sector read sequencer:
// FSM states, completion status codes, address-mark bytes and CRC constants.
package mfm_sector_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_WAIT_DAM,
    ST_MARK,
    ST_DATA,
    ST_CRC
  } state_t;

  typedef enum logic [1:0] {
    STS_OK        = 2'd0,
    STS_NOT_FOUND = 2'd1,
    STS_CRC_ERR   = 2'd2,
    STS_BAD_SIZE  = 2'd3
  } status_t;

  localparam logic [7:0] MARK_IDAM = 8'hFE;
  localparam logic [7:0] MARK_DAM  = 8'hFB;
  localparam logic [7:0] MARK_DDAM = 8'hF8;

  // CCITT CRC already advanced over the three A1 sync bytes.
  localparam logic [15:0] CRC_PRESET = 16'hCDB4;
  localparam logic [15:0] CRC_POLY   = 16'h1021;

endpackage

// File: rtl/mfm_sector_reader_crc16.sv
// Byte-wide CRC-16/CCITT (MSB first) with seed load and update enable.
// crc_next is the CRC after absorbing data; a field is good when it is 0 on the last byte.
module crc16_ccitt
  import mfm_sector_reader_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  logic [15:0] crc_q;
  logic [15:0] crc_base;

  function automatic logic [15:0] next_crc(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {din, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Loading and updating in the same cycle absorbs data on top of the seed.
  assign crc_base = load ? seed : crc_q;
  assign crc_next = next_crc(crc_base, data);

  always_ff @(posedge clk) begin
    if (en)        crc_q <= crc_next;
    else if (load) crc_q <= seed;
  end

endmodule

// File: rtl/mfm_sector_reader.sv
// Read-one-sector sequencer: waits for the matching ID header, captures the
// following data field, streams its payload with offsets and reports CRC status.
module mfm_sector_reader
  import mfm_sector_reader_pkg::*;
#(
  parameter int clkspd   = 65000000,
  parameter int MAX_REVS = 2,
  parameter int MAX_SIZE = 3
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Req,
  input  logic [7:0] i_ReqTrack,
  input  logic [7:0] i_ReqSide,
  input  logic [7:0] i_ReqSector,
  input  logic       i_Index,
  input  logic       i_Sync,
  input  logic [7:0] i_Data,
  input  logic       i_Valid,
  input  logic       i_HdrValid,
  input  logic [7:0] i_HdrTrack,
  input  logic [7:0] i_HdrSide,
  input  logic [7:0] i_HdrSector,
  input  logic [7:0] i_HdrSize,
  output logic       o_Busy,
  output logic [7:0] o_Byte,
  output logic       o_ByteValid,
  output logic [9:0] o_ByteAddr,
  output logic       o_Done,
  output logic [1:0] o_Status
);

  localparam int TMO_CYCLES = clkspd / 500;
  localparam int TMO_W      = $clog2(TMO_CYCLES + 1);
  localparam int REV_W      = $clog2(MAX_REVS + 1);
  localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TMO_CYCLES);
  localparam logic [REV_W-1:0] REV_LIM  = REV_W'(MAX_REVS);

  state_t            state, state_nxt;
  logic [7:0]        tgt_track, tgt_side, tgt_sector;
  logic [10:0]       n_bytes, byte_cnt;
  logic              crc_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [REV_W-1:0]  rev_cnt, rev_eff;

  logic              accept, ld_size, tmo_load, crc_load, crc_en, emit, last_byte;
  logic              done_nxt, hdr_match;
  logic [1:0]        status_nxt;
  logic [15:0]       crc_next;

  logic              vld_p1, done_p1, busy_p1;
  logic [7:0]        byte_p1;
  logic [9:0]        addr_p1;
  logic [1:0]        status_p1;

  crc16_ccitt u_crc (
    .clk      (i_Clk),
    .load     (crc_load),
    .seed     (CRC_PRESET),
    .en       (crc_en),
    .data     (i_Data),
    .crc_next (crc_next)
  );

  assign hdr_match = i_HdrValid && (i_HdrTrack == tgt_track) &&
                     (i_HdrSide == tgt_side) && (i_HdrSector == tgt_sector);

  // Index pulses count in every busy state; the counter saturates at the limit.
  assign rev_eff = (i_Index && rev_cnt < REV_LIM) ? rev_cnt + REV_W'(1) : rev_cnt;

  always_comb begin
    state_nxt  = state;
    status_nxt = status_p1;
    done_nxt   = 1'b0;
    accept     = 1'b0;
    ld_size    = 1'b0;
    tmo_load   = 1'b0;
    crc_load   = 1'b0;
    crc_en     = 1'b0;
    emit       = 1'b0;
    last_byte  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Req) begin
          accept    = 1'b1;
          state_nxt = ST_SEEK;
        end
      end
      ST_SEEK: begin
        // A matching header beats a same-cycle index pulse.
        if (hdr_match) begin
          if (i_HdrSize > 8'(MAX_SIZE)) begin
            done_nxt   = 1'b1;
            status_nxt = STS_BAD_SIZE;
            state_nxt  = ST_IDLE;
          end else begin
            ld_size   = 1'b1;
            tmo_load  = 1'b1;
            state_nxt = ST_WAIT_DAM;
          end
        end else if (rev_eff >= REV_LIM) begin
          done_nxt   = 1'b1;
          status_nxt = STS_NOT_FOUND;
          state_nxt  = ST_IDLE;
        end
      end
      ST_WAIT_DAM: begin
        if (i_Sync)             state_nxt = ST_MARK;
        else if (tmo_cnt == '0) state_nxt = ST_SEEK;
      end
      ST_MARK: begin
        if (i_Valid) begin
          if (i_Data == MARK_DAM || i_Data == MARK_DDAM) begin
            crc_load  = 1'b1;
            crc_en    = 1'b1;
            state_nxt = ST_DATA;
          end else if (i_Data == MARK_IDAM) begin
            state_nxt = ST_SEEK;
          end else begin
            state_nxt = ST_WAIT_DAM;
          end
        end
      end
      ST_DATA: begin
        if (i_Sync) begin
          state_nxt = ST_SEEK;
        end else if (i_Valid) begin
          emit   = 1'b1;
          crc_en = 1'b1;
          if (byte_cnt + 11'd1 == n_bytes) begin
            last_byte = 1'b1;
            state_nxt = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (i_Sync) begin
          state_nxt = ST_SEEK;
        end else if (i_Valid) begin
          crc_en = 1'b1;
          if (crc_cnt) begin
            done_nxt   = 1'b1;
            status_nxt = (crc_next == 16'h0000) ? STS_OK : STS_CRC_ERR;
            state_nxt  = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (accept) begin
      tgt_track  <= i_ReqTrack;
      tgt_side   <= i_ReqSide;
      tgt_sector <= i_ReqSector;
    end
    if (ld_size) n_bytes <= 11'd128 << i_HdrSize[1:0];
    if (tmo_load)                                 tmo_cnt <= TMO_INIT;
    else if (state == ST_WAIT_DAM && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);
    if (crc_load)  byte_cnt <= '0;
    else if (emit) byte_cnt <= byte_cnt + 11'd1;
    if (last_byte)                     crc_cnt <= 1'b0;
    else if (state == ST_CRC && crc_en) crc_cnt <= 1'b1;
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      state     <= ST_IDLE;
      rev_cnt   <= '0;
      vld_p1    <= 1'b0;
      byte_p1   <= '0;
      addr_p1   <= '0;
      done_p1   <= 1'b0;
      status_p1 <= '0;
      busy_p1   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rev_cnt   <= accept ? '0 : (state != ST_IDLE ? rev_eff : rev_cnt);
      vld_p1    <= emit;
      if (emit) begin
        byte_p1 <= i_Data;
        addr_p1 <= byte_cnt[9:0];
      end
      done_p1   <= done_nxt;
      status_p1 <= status_nxt;
      busy_p1   <= (state_nxt != ST_IDLE) || done_nxt;
    end
  end

  assign o_Busy      = busy_p1;
  assign o_Byte      = byte_p1;
  assign o_ByteValid = vld_p1;
  assign o_ByteAddr  = addr_p1;
  assign o_Done      = done_p1;
  assign o_Status    = status_p1;

endmodule

// File: doc/mfm_sector_reader.md
# mfm_sector_reader

Sequencer that sits behind the MFM decode chain (quantizer, sync detector, bit FIFO, sector header decoder) and turns it into a "read one sector" service. On a request for track/side/sector it watches decoded ID headers, waits for the matching one, then captures the following data field and streams its payload bytes with addresses. It checks the data CRC and reports done/status, giving up after a configurable number of index pulses.

## Interface
- `clkspd`, 65000000: clock frequency in Hz; sizes the DAM timeout.
- `MAX_REVS`, 2: index pulses tolerated before reporting not-found.
- `MAX_SIZE`, 3: largest accepted size code (128 << code bytes, i.e. 1024).
- `i_Clk` in 1: sole clock.
- `i_Reset` in 1: synchronous, active-low reset.
- `i_Req` in 1: one-cycle request strobe; sampled only in IDLE.
- `i_ReqTrack` / `i_ReqSide` / `i_ReqSector` in 8 each: target ID, latched on accepted `i_Req`.
- `i_Index` in 1: one-cycle index pulse, already synchronised.
- `i_Sync` in 1: A1 sync-mark pulse from the sync detector.
- `i_Data` in 8 / `i_Valid` in 1: decoded byte stream from the bit FIFO.
- `i_HdrValid` in 1: one-cycle strobe from the header decoder (CRC-good ID).
- `i_HdrTrack` / `i_HdrSide` / `i_HdrSector` / `i_HdrSize` in 8 each: decoded ID fields, valid with `i_HdrValid`.
- `o_Busy` out 1: high from accepted request until the `o_Done` cycle, inclusive.
- `o_Byte` out 8 / `o_ByteValid` out 1 / `o_ByteAddr` out 10: payload bytes with offset 0..N-1.
- `o_Done` out 1: one-cycle completion pulse.
- `o_Status` out 2: 0 = OK, 1 = not found, 2 = CRC error, 3 = bad size. Held from `o_Done` until the next accepted request.

## Operation
- IDLE: when `i_Req` is high, latch the target, clear the revolution counter, go to SEEK.
- SEEK:
  - Each `i_Index` increments the revolution counter. When the counter reaches `MAX_REVS`, finish with status 1.
  - On `i_HdrValid` with all three fields equal to the target:
    - If `i_HdrSize` > `MAX_SIZE`, finish with status 3.
    - Otherwise latch N = 128 << size and go to WAIT_DAM.
  - Non-matching headers are ignored.
- WAIT_DAM:
  - Load the timeout counter with clkspd/500 (2 ms) on entry.
  - On `i_Sync`, go to MARK.
  - When the counter reaches 0, return to SEEK. The revolution count is kept.
- MARK:
  - First `i_Valid` byte after sync: 0xFB or 0xF8 → DATA, with CRC preset to 0xCDB4 (CCITT over A1 A1 A1) and then updated with the mark byte.
  - 0xFE (a new ID field) → SEEK.
  - Any other byte → WAIT_DAM, timeout not reloaded.
- DATA:
  - Each `i_Valid` byte is fed to the CRC and emitted on `o_Byte` with `o_ByteAddr` = running count.
  - After N bytes, go to CRC.
- CRC:
  - Feed two more `i_Valid` bytes to the CRC.
  - Residue 0x0000 → status 0, else status 2.
  - Pulse `o_Done` and return to IDLE.
- `i_Sync` during DATA or CRC: abort to SEEK with no `o_Done`. Bytes already emitted stand; the consumer discards them on the next address 0.
- `i_Index` during WAIT_DAM/MARK/DATA/CRC still counts, but the limit is only evaluated in SEEK.
- `i_Req` while busy is ignored, with no queueing.
- Reset (any state):
  - State goes to IDLE.
  - All outputs go to 0, including `o_Status` = 0.
  - No `o_Done` is produced for the aborted operation.

## Timing
- Request latency: `i_Req` at cycle t gives `o_Busy` = 1 at t+1.
- Byte latency: `i_Valid` byte at t gives `o_ByteValid` at t+1. Output is registered and never back-pressured.
- Done timing: `o_Done` and `o_Status` are valid the cycle after the second CRC byte's `i_Valid`, or the cycle after the terminating `i_Index`/`i_HdrValid`.
- `o_Busy` drops the cycle after `o_Done`.
- Arithmetic:
  - CRC-16: polynomial 0x1021, MSB first, one byte per update.
  - Byte counter is 11 bits, compared against N.
  - `o_ByteAddr` is the low 10 bits.
- Same-cycle tie-break: if `i_Index` and a matching `i_HdrValid` arrive together in SEEK, the header wins.

## Structure
- Shared package holds:
  - state enum (IDLE, SEEK, WAIT_DAM, MARK, DATA, CRC);
  - status codes;
  - mark constants 0xFE, 0xFB, 0xF8;
  - CRC preset 0xCDB4 and polynomial 0x1021.
- Sub-module `crc16_ccitt`: byte-wide combinational next-CRC function plus a register with load/enable, reusable by the header decoder.

## Test plan
- Target T2/S0/R5, size 1:
  - Stimulus: headers R3, R4, R5, then sync, 0xFB, 256 bytes 0x00..0xFF, correct CRC.
  - Required: 256 `o_ByteValid` with addresses 0..255, then `o_Done` with status 0.
- Same stream with the last CRC byte flipped → `o_Done` with status 2, 256 bytes still emitted.
- Target R9, only R1–R8 present:
  - Stimulus: two `i_Index` pulses.
  - Required: `o_Done` with status 1 one cycle after the second pulse; no byte output.
- Matching header with size 4 → status 3 the cycle after `i_HdrValid`.
- DAM handling:
  - Matching header, no sync for 130000 cycles → back to SEEK, no `o_Done`.
  - Next revolution supplies the data field → status 0.
- Reset mid-operation:
  - Stimulus: `i_Reset` = 0 for one cycle at payload byte 100.
  - Required: all outputs 0 next cycle; a new `i_Req` is accepted afterwards. Also, `i_Req` while busy is ignored.
